// File: rtl/i2s_pkg.sv
// Shared defaults and sample types for the I2S transmitter.
package i2s_pkg;

  localparam int I2S_DATA_W   = 24;
  localparam int I2S_SLOT_W   = 32;
  localparam int I2S_MCLK_DIV = 8;

  typedef logic [I2S_DATA_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

endpackage

// File: rtl/i2s_clk_div.sv
// Bit-clock / word-select generator: divides mclk into sclk and tracks the bit position in the frame.
module i2s_clk_div #(
  parameter int SLOT_W   = 32,
  parameter int MCLK_DIV = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          sclk,
  output logic                          lrck,
  output logic                          fall,
  output logic                          frame_start,
  output logic [$clog2(2*SLOT_W)-1:0]   k,
  output logic                          right
);

  localparam int DW = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
  localparam int BW = $clog2(2*SLOT_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(MCLK_DIV-1);
  localparam logic [DW-1:0] DIV_HALF = DW'(MCLK_DIV/2);
  localparam logic [BW-1:0] BIT_LAST = BW'(2*SLOT_W-1);
  localparam logic [BW-1:0] SLOT     = BW'(SLOT_W);

  logic [DW-1:0] div_cnt, div_next;
  logic [BW-1:0] bit_cnt, bit_next;

  assign fall        = (div_cnt == DIV_LAST);
  assign frame_start = fall && (bit_cnt == BIT_LAST);

  always_comb begin
    div_next = fall ? '0 : div_cnt + DW'(1);
    bit_next = bit_cnt;
    if (fall) begin
      bit_next = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
    end
  end

  // k and right describe the bit that starts on the upcoming falling edge
  assign right = (bit_next >= SLOT);
  assign k     = right ? bit_next - SLOT : bit_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= BIT_LAST;
      sclk    <= 1'b0;
      lrck    <= 1'b1;
    end else begin
      div_cnt <= div_next;
      bit_cnt <= bit_next;
      sclk    <= (div_next >= DIV_HALF);
      lrck    <= (bit_next >= SLOT);
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep sample-pair buffer feeding left/right shift registers, MSB-first with one-bit delay.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W   = I2S_DATA_W,
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter int MCLK_DIV = I2S_MCLK_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              sclk,
  output logic              lrck,
  output logic              sdata,
  output logic              underrun
);

  localparam int BW = $clog2(2*SLOT_W);
  localparam logic [BW-1:0] K_LAST = BW'(DATA_W);

  logic              fall, frame_start, right;
  logic [BW-1:0]     k;
  logic              pend_valid;
  logic [DATA_W-1:0] pend_l, pend_r, sh_l, sh_r;
  logic              accept, in_data;

  i2s_clk_div #(.SLOT_W(SLOT_W), .MCLK_DIV(MCLK_DIV)) u_clk_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .lrck        (lrck),
    .fall        (fall),
    .frame_start (frame_start),
    .k           (k),
    .right       (right)
  );

  assign s_ready = !pend_valid;
  assign accept  = s_valid && s_ready;
  assign in_data = (k != '0) && (k <= K_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_l     <= '0;
      pend_r     <= '0;
      sh_l       <= '0;
      sh_r       <= '0;
      sdata      <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= frame_start && !pend_valid;
      // An accept on the frame-start edge lands in pend, never straight in the shifters
      if (frame_start) begin
        pend_valid <= accept;
      end else if (accept) begin
        pend_valid <= 1'b1;
      end
      if (accept) begin
        pend_l <= s_left;
        pend_r <= s_right;
      end
      if (frame_start) begin
        sh_l  <= pend_valid ? pend_l : '0;
        sh_r  <= pend_valid ? pend_r : '0;
        sdata <= 1'b0;
      end else if (fall) begin
        if (in_data) begin
          sdata <= right ? sh_r[DATA_W-1] : sh_l[DATA_W-1];
          if (right) begin
            sh_r <= sh_r << 1;
          end else begin
            sh_l <= sh_l << 1;
          end
        end else begin
          sdata <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: frame-level reference model checked every clk cycle plus directed corner cases.
module tb_i2s_tx;

  localparam int DW    = 24;
  localparam int SW    = 32;
  localparam int MD    = 8;
  localparam int FRAME = 2*SW*MD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_left = '0;
  logic [DW-1:0] s_right = '0;
  logic          s_ready, sclk, lrck, sdata, underrun;

  i2s_tx #(.DATA_W(DW), .SLOT_W(SW), .MCLK_DIV(MD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_left   (s_left),
    .s_right  (s_right),
    .sclk     (sclk),
    .lrck     (lrck),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miscompares = 0;

  // Reference model: edges since reset release, pending pair, pair on air this frame
  int            t;
  bit            m_pend;
  logic [DW-1:0] m_pl, m_pr, m_cl, m_cr;
  bit            m_ur;
  bit            last_acc;

  typedef struct {
    int edge_n;
    bit sclk_e;
    bit lrck_e;
    bit ur_e;
  } start_vec_t;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  start_vec_t sv[6];
  pair_t      pairs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  function automatic int bit_pos();
    return ((t / MD) + 2*SW - 1) % (2*SW);
  endfunction

  task automatic reset_model();
    t = 0; m_pend = 0; m_pl = '0; m_pr = '0; m_cl = '0; m_cr = '0; m_ur = 0; last_acc = 0;
  endtask

  task automatic check_outputs();
    int            b, k;
    logic [DW-1:0] w;
    bit            sd;
    if (!rst_n) begin
      chk("rst_sclk", sclk, 0);
      chk("rst_lrck", lrck, 1);
      chk("rst_sdata", sdata, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_ready", s_ready, 1);
    end else begin
      b  = bit_pos();
      k  = b % SW;
      w  = (b < SW) ? m_cl : m_cr;
      sd = (k >= 1 && k <= DW) ? w[DW-k] : 1'b0;
      chk("sclk", sclk, ((t % MD) >= MD/2) ? 1 : 0);
      chk("lrck", lrck, (b >= SW) ? 1 : 0);
      chk("sdata", sdata, sd);
      chk("underrun", underrun, m_ur);
      chk("s_ready", s_ready, !m_pend);
    end
  endtask

  task automatic step(input bit v, input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit acc, fs;
    s_valid = v; s_left = l; s_right = r;
    @(posedge clk);
    if (!rst_n) begin
      reset_model();
    end else begin
      acc = v && !m_pend;
      t++;
      fs   = ((t % FRAME) == MD);
      m_ur = fs && !m_pend;
      if (fs) begin
        m_cl   = m_pend ? m_pl : '0;
        m_cr   = m_pend ? m_pr : '0;
        m_pend = 0;
      end
      if (acc) begin
        m_pend = 1; m_pl = l; m_pr = r;
        $display("accept L=%h R=%h at edge %0d", l, r, t);
      end
      last_acc = acc;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    int ur_cnt, ones, guard;
    sv[0] = '{3, 0, 1, 0};
    sv[1] = '{4, 1, 1, 0};
    sv[2] = '{7, 1, 1, 0};
    sv[3] = '{8, 0, 0, 1};
    sv[4] = '{9, 0, 0, 0};
    sv[5] = '{12, 1, 0, 0};
    pairs[0] = '{24'hA5A5A5, 24'h5A5A5A};
    pairs[1] = '{24'h800000, 24'h7FFFFF};
    pairs[2] = '{24'hFFFFFF, 24'h000001};
    pairs[3] = '{24'h123456, 24'hFEDCBA};
    reset_model();

    // Reset held with s_valid high: handshake must be ignored
    for (int i = 0; i < 10; i++) step(1, 24'h111111, 24'h222222);
    rst_n = 1'b1;

    // Startup edges, no data offered
    for (int i = 0; i < 6; i++) begin
      while (t < sv[i].edge_n) step(0, '0, '0);
      chk("start_sclk", sclk, sv[i].sclk_e);
      chk("start_lrck", lrck, sv[i].lrck_e);
      chk("start_underrun", underrun, sv[i].ur_e);
    end

    // Backpressure: s_valid held high across all pairs
    for (int i = 0; i < 4; i++) begin
      guard = 0;
      do begin
        step(1, pairs[i].l, pairs[i].r);
        guard++;
      end while (!last_acc && guard < 3*FRAME);
      chk("pair_accepted", last_acc, 1);
    end
    for (int i = 0; i < 2*FRAME + 16; i++) step(0, '0, '0);

    // Starvation
    ur_cnt = 0; ones = 0;
    for (int i = 0; i < 4*FRAME; i++) begin
      step(0, '0, '0);
      ur_cnt += underrun;
      ones   += sdata;
    end
    chk("starve_underruns", ur_cnt, 4);
    chk("starve_sdata_ones", ones, 0);

    // Offer exactly on the frame-start edge with an empty buffer
    while (((t + 1) % FRAME) != MD) step(0, '0, '0);
    step(1, 24'hC3C3C3, 24'h3C3C3C);
    chk("simul_underrun", underrun, 1);
    chk("simul_ready", s_ready, 0);
    for (int i = 0; i < 2*FRAME; i++) step(0, '0, '0);

    // Randomized traffic
    for (int i = 0; i < 6*FRAME; i++) begin
      step(($urandom_range(0, 3) == 0), DW'($urandom), DW'($urandom));
    end
    for (int i = 0; i < FRAME + 16; i++) step(0, '0, '0);

    // Asynchronous reset mid-frame with a pair pending
    while (((t + 1) % FRAME) != MD) step(0, '0, '0);
    step(1, 24'hDEADBE, 24'hEF1234);
    while (bit_pos() != 40) step(0, '0, '0);
    chk("pending_before_reset", s_ready, 0);
    #2;
    rst_n = 1'b0;
    reset_model();
    #1;
    check_outputs();
    for (int i = 0; i < 3; i++) step(0, '0, '0);
    rst_n = 1'b1;
    ones = 0;
    for (int i = 0; i < 3*FRAME; i++) begin
      step(0, '0, '0);
      ones += sdata;
    end
    chk("post_reset_silent", ones, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
